// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned PC_WIDTH   = 64;
  localparam int unsigned INST_WIDTH = 32;
  localparam int unsigned BEAT_WIDTH = 64;
  localparam int unsigned LINE_BYTES = 64;
  localparam int unsigned LINE_BEATS = 8;
  localparam int unsigned LINE_OFF_W = $clog2(LINE_BYTES);
  localparam int unsigned BEAT_IDX_W = $clog2(LINE_BEATS);
  localparam int unsigned WORD_IDX_W = $clog2(LINE_BYTES / 4);

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_8B    = 3'd3;
  localparam logic [2:0] AXI_PROT_INSN  = 3'b100;
  localparam logic [7:0] AXI_LEN_LINE   = 8'(LINE_BEATS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_DELIVER,
    ST_FAULT
  } fetch_state_t;

  typedef struct packed {
    logic [PC_WIDTH-1:0] addr;
    logic [7:0]          len;
    logic [2:0]          size;
    logic [1:0]          burst;
    logic [2:0]          prot;
  } ar_req_t;

  // Byte address of the first byte of the line holding pc.
  function automatic logic [PC_WIDTH-1:0] line_base(input logic [PC_WIDTH-1:0] pc);
    return {pc[PC_WIDTH-1:LINE_OFF_W], LINE_OFF_W'(0)};
  endfunction

endpackage

// File: rtl/fetch_line_buf.sv
// One cache-line buffer: written a beat at a time, read a 32-bit word at a time.
module fetch_line_buf
  import fetch_pkg::*;
(
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [BEAT_IDX_W-1:0] wr_beat,
  input  logic [BEAT_WIDTH-1:0] wr_data,
  input  logic [WORD_IDX_W-1:0] rd_word,
  output logic [INST_WIDTH-1:0] rd_data_c
);

  logic [BEAT_WIDTH-1:0] line_q [LINE_BEATS];
  logic [BEAT_WIDTH-1:0] beat_sel;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      line_q[wr_beat] <= wr_data;
    end
  end

  // Lower-addressed word sits in the low half of each little-endian beat.
  assign beat_sel  = line_q[rd_word[WORD_IDX_W-1:1]];
  assign rd_data_c = rd_word[0] ? beat_sel[BEAT_WIDTH-1:INST_WIDTH] : beat_sel[INST_WIDTH-1:0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: line refill over AXI AR/R, then streams words to decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = 13,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned FETCH_ID   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PC_WIDTH-1:0]   entry,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  inst_valid,
  output logic [INST_WIDTH-1:0] inst,
  output logic [PC_WIDTH-1:0]   inst_pc,
  input  logic                  inst_ready,
  output logic                  fetch_fault,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  fetch_state_t          state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [PC_WIDTH-1:0]   pending_pc_q, pending_pc_d;
  logic                  pending_valid_q, pending_valid_d;
  logic                  err_q, err_d;
  logic [BEAT_IDX_W-1:0] beat_q, beat_d;

  logic [PC_WIDTH-1:0]   redirect_pc_al;
  logic                  beat_fire_c;
  logic                  beat_err_c;
  logic                  last_beat_c;
  logic [INST_WIDTH-1:0] line_word_c;
  ar_req_t               ar_req_c;
  logic                  unused_rid;

  assign redirect_pc_al = {redirect_pc[PC_WIDTH-1:2], 2'b00};
  assign unused_rid     = ^m_axi_rid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      pc_q            <= entry;
      pending_pc_q    <= '0;
      pending_valid_q <= 1'b0;
      err_q           <= 1'b0;
      beat_q          <= '0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      pending_pc_q    <= pending_pc_d;
      pending_valid_q <= pending_valid_d;
      err_q           <= err_d;
      beat_q          <= beat_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    pending_pc_d    = pending_pc_q;
    pending_valid_d = pending_valid_q;
    err_d           = err_q;
    beat_d          = beat_q;
    beat_fire_c     = 1'b0;
    beat_err_c      = 1'b0;
    last_beat_c     = 1'b0;

    case (state_q)
      ST_IDLE: state_d = ST_AR;

      ST_AR: begin
        // The request cannot be withdrawn; remember where to go afterwards.
        if (redirect_valid) begin
          pending_pc_d    = redirect_pc_al;
          pending_valid_d = 1'b1;
        end
        if (m_axi_arready) begin
          state_d = ST_R;
          beat_d  = '0;
          err_d   = 1'b0;
        end
      end

      ST_R: begin
        if (redirect_valid) begin
          pending_pc_d    = redirect_pc_al;
          pending_valid_d = 1'b1;
        end
        if (m_axi_rvalid) begin
          beat_fire_c = 1'b1;
          beat_err_c  = (m_axi_rresp != 2'b00) ||
                        (m_axi_rlast && (beat_q != BEAT_IDX_W'(LINE_BEATS - 1)));
          last_beat_c = m_axi_rlast || (beat_q == BEAT_IDX_W'(LINE_BEATS - 1));
          beat_d      = beat_q + BEAT_IDX_W'(1);
          err_d       = err_q | beat_err_c;
          if (last_beat_c) begin
            if (err_d) begin
              state_d = ST_FAULT;
            end else if (pending_valid_d) begin
              state_d         = ST_AR;
              pc_d            = pending_pc_d;
              pending_valid_d = 1'b0;
            end else begin
              state_d = ST_DELIVER;
            end
          end
        end
      end

      ST_DELIVER: begin
        // A redirect discards the word on offer even if decode took it.
        if (redirect_valid) begin
          pc_d    = redirect_pc_al;
          state_d = ST_AR;
        end else if (inst_ready) begin
          pc_d = pc_q + PC_WIDTH'(4);
          if (pc_q[LINE_OFF_W-1:2] == '1) begin
            state_d = ST_AR;
          end
        end
      end

      ST_FAULT: state_d = ST_FAULT;

      default: state_d = ST_IDLE;
    endcase
  end

  fetch_line_buf u_line_buf (
    .clk       (clk),
    .wr_en     (beat_fire_c),
    .wr_beat   (beat_q),
    .wr_data   (BEAT_WIDTH'(m_axi_rdata)),
    .rd_word   (pc_q[LINE_OFF_W-1:2]),
    .rd_data_c (line_word_c)
  );

  // Outputs are pure decodes of registered state, forced low while in reset.
  assign m_axi_arvalid = !reset && (state_q == ST_AR);
  assign m_axi_rready  = !reset && (state_q == ST_R);
  assign inst_valid    = !reset && (state_q == ST_DELIVER);
  assign fetch_fault   = !reset && (state_q == ST_FAULT);

  always_comb begin
    ar_req_c = '0;
    if (m_axi_arvalid) begin
      ar_req_c.addr  = line_base(pc_q);
      ar_req_c.len   = AXI_LEN_LINE;
      ar_req_c.size  = AXI_SIZE_8B;
      ar_req_c.burst = AXI_BURST_INCR;
      ar_req_c.prot  = AXI_PROT_INSN;
    end
  end

  assign m_axi_arid    = m_axi_arvalid ? ID_WIDTH'(FETCH_ID) : '0;
  assign m_axi_araddr  = ADDR_WIDTH'(ar_req_c.addr);
  assign m_axi_arlen   = ar_req_c.len;
  assign m_axi_arsize  = ar_req_c.size;
  assign m_axi_arburst = ar_req_c.burst;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0000;
  assign m_axi_arprot  = ar_req_c.prot;

  assign inst    = inst_valid ? line_word_c : '0;
  assign inst_pc = inst_valid ? pc_q : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit with a small AXI read-slave model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] entry;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_ready;
  logic        fetch_fault;
  logic [12:0] m_axi_arid;
  logic [63:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arlock;
  logic [3:0]  m_axi_arcache;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [12:0] m_axi_rid;
  logic [63:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;

  always #5 clk = ~clk;

  fetch_unit #(
    .ID_WIDTH  (13),
    .ADDR_WIDTH(64),
    .DATA_WIDTH(64),
    .FETCH_ID  (0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .entry         (entry),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_ready    (inst_ready),
    .fetch_fault   (fetch_fault),
    .m_axi_arid    (m_axi_arid),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arlen   (m_axi_arlen),
    .m_axi_arsize  (m_axi_arsize),
    .m_axi_arburst (m_axi_arburst),
    .m_axi_arlock  (m_axi_arlock),
    .m_axi_arcache (m_axi_arcache),
    .m_axi_arprot  (m_axi_arprot),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rid     (m_axi_rid),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rlast   (m_axi_rlast),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready)
  );

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] word;
  } exp_inst_t;

  // {arid, arlen, arsize, arburst, arlock, arcache, arprot}
  localparam logic [33:0] AR_CTRL_EXP = {13'd0, 8'd7, 3'd3, 2'b01, 1'b0, 4'd0, 3'b100};

  exp_inst_t   exp_inst_q[$];
  logic [63:0] exp_ar_q[$];
  int n_checks = 0;
  int n_errors = 0;

  // Slave controls (stimulus) and slave state (slave process only)
  int          ar_delay = 0;
  int          err_beat = -1;
  logic        stray    = 1'b0;
  logic        burst_on = 1'b0;
  int          s_beat   = 0;
  int          ar_wait  = 0;
  logic [63:0] burst_addr = '0;

  int cyc;
  int drained;
  int n_stray;

  // Memory image: word at 0x1000_0000 + 4i holds i (wraps elsewhere).
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return 32'((a - 64'h1000_0000) >> 2);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_unexpected(input string name, input logic [63:0] act);
    n_checks++;
    n_errors++;
    $display("FAIL %s: actual=0x%0h required=nothing at %0t", name, act, $time);
  endtask

  task automatic push_inst(input logic [63:0] pc, input logic [31:0] word);
    exp_inst_t e;
    e.pc   = pc;
    e.word = word;
    exp_inst_q.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctrl"}, 64'({m_axi_arvalid, m_axi_rready, inst_valid, fetch_fault,
                               m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock,
                               m_axi_arcache, m_axi_arprot, m_axi_arid}), 64'd0);
    check({tag, "_araddr"}, m_axi_araddr, 64'd0);
    check({tag, "_inst"}, 64'(inst), 64'd0);
    check({tag, "_inst_pc"}, inst_pc, 64'd0);
  endtask

  task automatic do_reset(input logic [63:0] entry_v);
    @(posedge clk); #1;
    reset          = 1'b1;
    entry          = entry_v;
    redirect_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_zero("in_reset");
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int c = 0;
    while ((exp_ar_q.size() != 0 || exp_inst_q.size() != 0) && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(name, 64'(exp_ar_q.size() + exp_inst_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  // AXI read slave: 8-beat bursts from the memory image, optional error beat and stray beats.
  initial begin
    logic        ar_hs, r_hs;
    logic [63:0] hs_addr, a;
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b0;
    m_axi_rdata   = '0;
    m_axi_rresp   = '0;
    m_axi_rlast   = 1'b0;
    m_axi_rid     = '0;
    forever begin
      @(negedge clk);
      ar_hs   = m_axi_arvalid && m_axi_arready;
      r_hs    = m_axi_rvalid && m_axi_rready;
      hs_addr = m_axi_araddr;
      @(posedge clk); #1;
      if (reset) begin
        burst_on = 1'b0;
        s_beat   = 0;
        ar_wait  = 0;
      end else begin
        if (ar_hs) begin
          burst_on   = 1'b1;
          s_beat     = 0;
          burst_addr = hs_addr;
          ar_wait    = 0;
        end else if (r_hs && burst_on) begin
          if (s_beat == 7) burst_on = 1'b0;
          else s_beat++;
        end
        if (!burst_on && m_axi_arvalid) ar_wait++;
      end
      m_axi_arready = !reset && !burst_on && m_axi_arvalid && (ar_wait > ar_delay);
      if (burst_on) begin
        a            = burst_addr + 64'(8 * s_beat);
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = {mem_word(a + 64'd4), mem_word(a)};
        m_axi_rresp  = (s_beat == err_beat) ? 2'b10 : 2'b00;
        m_axi_rlast  = (s_beat == 7);
      end else if (stray && !m_axi_arready) begin
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = '1;
        m_axi_rresp  = 2'b10;
        m_axi_rlast  = 1'b1;
      end else begin
        m_axi_rvalid = 1'b0;
        m_axi_rdata  = '0;
        m_axi_rresp  = 2'b00;
        m_axi_rlast  = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every AR and instruction handshake.
  initial begin
    logic [63:0] ea;
    exp_inst_t   ei;
    forever begin
      @(negedge clk);
      if (!reset && m_axi_arvalid && m_axi_arready) begin
        if (exp_ar_q.size() == 0) begin
          fail_unexpected("ar_unexpected", m_axi_araddr);
        end else begin
          ea = exp_ar_q.pop_front();
          check("ar_addr", m_axi_araddr, ea);
          check("ar_ctrl", 64'({m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst,
                                m_axi_arlock, m_axi_arcache, m_axi_arprot}), 64'(AR_CTRL_EXP));
        end
      end
      if (!reset && inst_valid && inst_ready && !redirect_valid) begin
        if (exp_inst_q.size() == 0) begin
          fail_unexpected("inst_unexpected", inst_pc);
        end else begin
          ei = exp_inst_q.pop_front();
          check("inst_pc", inst_pc, ei.pc);
          check("inst_word", 64'(inst), 64'(ei.word));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset          = 1'b1;
    entry          = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;

    // 1: sequential line from entry 0x1000_0004, then next-line AR
    inst_ready = 1'b1;
    do_reset(64'h1000_0004);
    exp_ar_q.push_back(64'h1000_0000);
    for (int i = 1; i < 16; i++) push_inst(64'h1000_0000 + 64'(4 * i), 32'(i));
    exp_ar_q.push_back(64'h1000_0040);
    @(negedge clk);
    check("t1_idle_arvalid", 64'(m_axi_arvalid), 64'd0);
    @(negedge clk);
    check("t1_ar_arvalid", 64'(m_axi_arvalid), 64'd1);
    wait_drain(200, "t1_drain");
    inst_ready = 1'b0;

    // 2: arready held low 10 cycles with stray R beats offered
    stray      = 1'b1;
    ar_delay   = 10;
    inst_ready = 1'b1;
    do_reset(64'h1000_0100);
    exp_ar_q.push_back(64'h1000_0100);
    for (int i = 0; i < 16; i++) push_inst(64'h1000_0100 + 64'(4 * i), 32'h40 + 32'(i));
    exp_ar_q.push_back(64'h1000_0140);
    cyc = 0;
    @(negedge clk);
    while (!m_axi_arvalid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    for (int k = 0; k < 10; k++) begin
      check("t2_arvalid_hold", 64'(m_axi_arvalid), 64'd1);
      check("t2_araddr_hold", m_axi_araddr, 64'h1000_0100);
      check("t2_no_early_rready", 64'(m_axi_rready), 64'd0);
      @(negedge clk);
    end
    stray = 1'b0;
    wait_drain(400, "t2_drain");
    inst_ready = 1'b0;
    ar_delay   = 0;

    // 3: redirect to 0x2002 during beat 3; burst drains, then refetch at 0x2000
    inst_ready = 1'b1;
    do_reset(64'h3000_0000);
    exp_ar_q.push_back(64'h3000_0000);
    exp_ar_q.push_back(64'h2000);
    for (int i = 0; i < 16; i++) push_inst(64'h2000 + 64'(4 * i), 32'hFC00_0800 + 32'(i));
    exp_ar_q.push_back(64'h2040);
    cyc = 0;
    do begin
      @(posedge clk); #2;
      cyc++;
    end while (!(burst_on && s_beat == 3 && m_axi_rready) && cyc < 40);
    check("t3_beat3_reached", 64'(s_beat), 64'd3);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h2002;
    @(negedge clk);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    drained = 0;
    cyc     = 0;
    while (cyc < 20) begin
      @(negedge clk);
      if (m_axi_arvalid) break;
      check("t3_no_inst_in_drain", 64'(inst_valid), 64'd0);
      if (m_axi_rvalid && m_axi_rready) drained++;
      cyc++;
    end
    check("t3_drained_beats", 64'(drained), 64'd4);
    wait_drain(200, "t3_drain");
    inst_ready = 1'b0;

    // 4: inst_ready 1-0-1 with a redirect on the ready cycle
    do_reset(64'h1000_0000);
    exp_ar_q.push_back(64'h1000_0000);
    push_inst(64'h1000_0000, 32'd0);
    push_inst(64'h1000_0004, 32'd1);
    exp_ar_q.push_back(64'h4000);
    for (int i = 0; i < 14; i++) push_inst(64'h4008 + 64'(4 * i), 32'hFC00_1002 + 32'(i));
    exp_ar_q.push_back(64'h4040);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!inst_valid && cyc < 40);
    inst_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    inst_ready = 1'b0;
    @(posedge clk); #1;
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h4008;
    @(negedge clk);
    check("t4_offered_pc", inst_pc, 64'h1000_0008);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    wait_drain(200, "t4_drain");
    inst_ready = 1'b0;

    // 5: SLVERR on beat 5 -> sticky fault; reset recovers
    inst_ready = 1'b1;
    err_beat   = 5;
    do_reset(64'h1000_0000);
    exp_ar_q.push_back(64'h1000_0000);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!fetch_fault && cyc < 40);
    check("t5_fault_seen", 64'(fetch_fault), 64'd1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("t5_fault_quiet", 64'({m_axi_arvalid, inst_valid, m_axi_rready, fetch_fault}), 64'd1);
    end
    err_beat   = -1;
    inst_ready = 1'b0;
    do_reset(64'h1000_0000);
    exp_ar_q.push_back(64'h1000_0000);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!inst_valid && cyc < 40);
    check("t5_restart_pc", inst_pc, 64'h1000_0000);
    check("t5_restart_word", 64'(inst), 64'd0);
    check("t5_fault_cleared", 64'(fetch_fault), 64'd0);
    wait_drain(20, "t5_drain");

    // 6: reset mid-burst; stray beats ignored in IDLE/AR
    inst_ready = 1'b0;
    do_reset(64'h1000_0000);
    exp_ar_q.push_back(64'h1000_0000);
    cyc = 0;
    do begin
      @(posedge clk); #2;
      cyc++;
    end while (!(burst_on && s_beat == 4) && cyc < 40);
    check("t6_beat4_reached", 64'(s_beat), 64'd4);
    reset    = 1'b1;
    stray    = 1'b1;
    ar_delay = 3;
    @(negedge clk);
    @(negedge clk);
    check_zero("t6_after_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    exp_ar_q.push_back(64'h1000_0000);
    n_stray = 0;
    cyc     = 0;
    while (cyc < 30) begin
      @(negedge clk);
      if (m_axi_rvalid && !burst_on) begin
        n_stray++;
        check("t6_stray_rready", 64'(m_axi_rready), 64'd0);
      end
      if (m_axi_arvalid && m_axi_arready) break;
      cyc++;
    end
    check("t6_stray_offered", 64'(n_stray > 0), 64'd1);
    stray    = 1'b0;
    ar_delay = 0;
    wait_drain(40, "t6_drain");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage feeding the core pipeline from the AXI read channel of the system bus. It holds a program counter initialised from `entry` and fetches the 64-byte line containing it as one 8-beat INCR burst into a line buffer. It then streams 32-bit instructions with their PCs to decode over a valid/ready handshake. Control-flow redirects from downstream restart fetch at a new PC.

## Interface
- `ID_WIDTH`, 13, AXI ID width
- `ADDR_WIDTH`, 64, AXI address width
- `DATA_WIDTH`, 64, AXI data width; only 64 is supported
- `FETCH_ID`, 0, constant driven on `m_axi_arid`
- `clk` in 1: the single clock
- `reset` in 1: synchronous, active-high
- `entry` in 64: PC loaded while `reset` is high
- `redirect_valid` in 1: restart fetch at `redirect_pc`
- `redirect_pc` in 64: new PC; bits [1:0] ignored and treated as 0
- `inst_valid` out 1: instruction available
- `inst` out 32: instruction word
- `inst_pc` out 64: address of `inst`
- `inst_ready` in 1: decode accepts the instruction
- `fetch_fault` out 1: sticky; a burst returned an error
- `m_axi_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid`: out, standard AXI AR channel
- `m_axi_arready` in 1: AR handshake
- `m_axi_rid/rdata/rresp/rlast/rvalid`: in, standard AXI R channel
- `m_axi_rready` out 1: R handshake

## Operation
- States: IDLE, AR, R, DELIVER, FAULT.
- Reset: state IDLE, `pc`=`entry`, `pending_valid`=0, `fetch_fault`=0. All outputs are 0 during reset.
- IDLE -> AR unconditionally.
- AR:
  - Drives `arvalid`=1, `araddr`={`pc`[63:6],6'b0}, `arlen`=7, `arsize`=3, `arburst`=2'b01 (INCR), `arlock`=0, `arcache`=0, `arprot`=3'b100 (instruction), `arid`=`FETCH_ID`.
  - `araddr` is stable until `arready`. On `arvalid`&&`arready` -> R with beat counter 0.
- R:
  - `rready`=1. Each `rvalid` beat is written to `buf[beat]` and the counter increments.
  - Any `rresp`!=0, or `rlast` on a beat other than 7, sets error-seen.
  - On the last beat: error-seen -> FAULT; else if `pending_valid` -> AR with `pc`=`pending_pc` and `pending_valid` cleared; else -> DELIVER.
  - `rid` is not checked; only one burst is outstanding.
- DELIVER:
  - `inst_valid`=1, `inst`=32-bit word `pc`[5:2] of the buffer, `inst_pc`=`pc`.
  - On a handshake: `pc`+=4. If `pc`[5:2] was 15 -> AR, which fetches the next sequential line.
- Redirects:
  - Any state except FAULT/IDLE, handled the same cycle.
  - In DELIVER: `pc`=`redirect_pc`&~3 -> AR. The buffer is always refetched.
  - In AR or R: the request or burst in flight cannot be cancelled. Latch `pending_pc`/`pending_valid`; the burst completes and its data is discarded. A later redirect overwrites the pending PC.
  - Redirect wins over a same-cycle `inst` handshake. That instruction counts as not consumed.
- FAULT: terminal until reset. `fetch_fault`=1, `inst_valid`=0, `arvalid`=0, `rready`=0.

## Timing
- `arvalid` rises on the 2nd cycle after `reset` deasserts: IDLE for one cycle, then AR.
- First `inst_valid` appears the cycle after the handshake of the rlast beat. No bypass from R to decode.
- In DELIVER, one instruction per cycle at full throughput.
- Line end: the cycle after the 16th handshake is in AR. Sequential refill takes ≥ 1 (AR) + 8 (beats) + 1 cycles.
- `pc` is 64-bit and wraps modulo 2^64 without a special case.
- `inst`, `inst_pc`, `inst_valid` depend only on registered state; no combinational path from `inst_ready`.

## Structure
- `fetch_pkg`: `fetch_state_t` enum, `LINE_BYTES`=64, `LINE_BEATS`=8, `AXI_BURST_INCR`=2'b01, `AXI_SIZE_8B`=3'd3, `AXI_PROT_INSN`=3'b100.
- Sub-module `fetch_line_buf`: 8x64 register array with one write port (beat index, data, enable) and a 32-bit read mux indexed by `pc`[5:2].
- Top-level wiring connects `fetch_unit` to the AR/R ports. AW/W/B remain owned by the data side.

## Test plan
- Reset with `entry`=0x1000_0004; memory words are word index i at 0x1000_0000+4i; `inst_ready`=1 -> one AR with `araddr`=0x1000_0000, `arlen`=7, `arsize`=3, `arburst`=1. Then `inst`=1..15 with `inst_pc` 0x…04..0x…3C, followed by AR at 0x1000_0040.
- `arready` held low 10 cycles -> `arvalid` and `araddr` stable throughout; no R beats accepted early.
- `redirect_valid` with `redirect_pc`=0x2002 during beat 3 of a burst -> remaining beats drained with `rready`=1 and no `inst_valid`. Then AR at 0x2000 and first `inst_pc`=0x2000.
- `inst_ready` toggled 1-0-1 while `redirect_valid` pulses in a cycle with `inst_ready`=1 -> that instruction is not counted and the next `inst_pc` is the redirect target.
- `rresp`=2'b10 on beat 5 -> after rlast, `fetch_fault`=1 and no `inst_valid` or `arvalid` until reset. A following reset clears `fetch_fault` and fetch restarts at `entry`.
- `reset` asserted mid-burst -> next cycle all outputs are 0. Stray R beats after reset deasserts are not accepted while in IDLE/AR.
